// File: rtl/pc_fetch_control.sv
// PC register and fetch sequencer for the KGP miniRISC core: boot, run, branch-flush
// bubble and terminal halt, with a fetch counter and a sticky misaligned-target flag.
module pc_fetch_control #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            halted,
  output logic            misalign,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    HALT
  } state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic            misalign_n;
  logic            count_en;
  logic            target_misaligned;

  // Alignment is only enforced for the word-sized instruction step.
  assign target_misaligned = (PC_STEP == 4) && (branch_target[1:0] != 2'b00);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    misalign_n = misalign;
    count_en   = 1'b0;
    case (state)
      BOOT:  state_n = halt ? HALT : RUN;
      RUN: begin
        if (halt) begin
          state_n = HALT;
        end else if (branch_taken && target_misaligned) begin
          state_n    = HALT;
          misalign_n = 1'b1;
        end else if (branch_taken) begin
          pc_n     = branch_target;
          state_n  = FLUSH;
          count_en = !stall;
        end else if (!stall) begin
          pc_n     = pc + PC_W'(PC_STEP);
          count_en = 1'b1;
        end
      end
      FLUSH: state_n = halt ? HALT : RUN;
      HALT:  state_n = HALT;
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      misalign <= misalign_n;
      if (count_en) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_fetch_control.sv
// Bench for pc_fetch_control: directed scenarios with literal expectations, then
// randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_pc_fetch_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_control #(
    .PC_W(32),
    .PC_STEP(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halt(halt),
    .pc(pc),
    .fetch_valid(fetch_valid),
    .halted(halted),
    .misalign(misalign),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: started/bubble/stopped flags plus plain arithmetic.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis, m_halted, m_started, m_bubble;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
      m_halted = 1'b0; m_started = 1'b0; m_bubble = 1'b0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (!m_started) begin
      m_started = 1'b1;
      if (halt) m_halted = 1'b1;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
      if (halt) m_halted = 1'b1;
    end else if (halt) begin
      m_halted = 1'b1;
    end else if (branch_taken && (branch_target % 4 != 0)) begin
      m_halted = 1'b1;
      m_mis    = 1'b1;
    end else begin
      if (!stall) m_cnt = m_cnt + 1;
      if (branch_taken) begin
        m_pc     = branch_target;
        m_bubble = 1'b1;
      end else if (!stall) begin
        m_pc = m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_pc", pc, m_pc);
    chk("model_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_started && !m_bubble && !m_halted});
    chk("model_halted", {31'b0, halted}, {31'b0, m_halted});
    chk("model_misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("model_fetch_count", fetch_count, m_cnt);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] e_pc, input logic e_fv,
                            input logic e_h, input logic e_m, input logic [31:0] e_cnt);
    chk({tag, "_pc"}, pc, e_pc);
    chk({tag, "_fv"}, {31'b0, fetch_valid}, {31'b0, e_fv});
    chk({tag, "_halted"}, {31'b0, halted}, {31'b0, e_h});
    chk({tag, "_misalign"}, {31'b0, misalign}, {31'b0, e_m});
    chk({tag, "_cnt"}, fetch_count, e_cnt);
  endtask

  initial begin
    // Reset release and sequential fetch
    do_reset();
    expect_out("boot", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(); expect_out("run0", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(); expect_out("run4", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
    cyc(); expect_out("run8", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);
    cyc(); expect_out("run12", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);
    cyc(); expect_out("run16", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4);
    // Stall three cycles at 0x10
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_out("stall", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4);
    end
    stall = 1'b0;
    cyc(); expect_out("unstall", 32'h14, 1'b1, 1'b0, 1'b0, 32'd5);
    cyc(); cyc(); cyc();
    expect_out("at20", 32'h20, 1'b1, 1'b0, 1'b0, 32'd8);
    // Branch overrides simultaneous stall
    branch_taken = 1'b1; branch_target = 32'h100; stall = 1'b1;
    cyc(); expect_out("flush", 32'h100, 1'b0, 1'b0, 1'b0, 32'd8);
    idle_inputs();
    cyc(); expect_out("target", 32'h100, 1'b1, 1'b0, 1'b0, 32'd8);
    cyc(); expect_out("after_tgt", 32'h104, 1'b1, 1'b0, 1'b0, 32'd9);
    // Misaligned target halts and sticks
    branch_taken = 1'b1; branch_target = 32'h102;
    cyc(); expect_out("misal", 32'h104, 1'b0, 1'b1, 1'b1, 32'd9);
    branch_target = 32'h200; stall = 1'b1;
    cyc(); cyc(); expect_out("halt_hold", 32'h104, 1'b0, 1'b1, 1'b1, 32'd9);
    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle_inputs();
    cyc(); rst = 1'b0;

    // halt beats branch in RUN
    do_reset();
    cyc(); cyc();
    halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    cyc(); expect_out("halt_br", 32'h4, 1'b0, 1'b1, 1'b0, 32'd1);
    // halt during FLUSH keeps target
    do_reset();
    cyc();
    branch_taken = 1'b1; branch_target = 32'h80;
    cyc(); expect_out("flush2", 32'h80, 1'b0, 1'b0, 1'b0, 32'd1);
    idle_inputs(); halt = 1'b1;
    cyc(); expect_out("halt_flush", 32'h80, 1'b0, 1'b1, 1'b0, 32'd1);

    // PC wrap at the top of the address space
    do_reset();
    cyc();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    cyc(); idle_inputs();
    cyc(); expect_out("wrap_f8", 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 32'd1);
    cyc(); expect_out("wrap_fc", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'd2);
    cyc(); expect_out("wrap_0", 32'h0, 1'b1, 1'b0, 1'b0, 32'd3);
    #2 rst = 1'b1;
    #1 expect_out("wrap_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(); rst = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst = 1'b0;
      stall = ($urandom_range(0, 3) == 0);
      halt = ($urandom_range(0, 199) == 0);
      branch_taken = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 9))
        0:       branch_target = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        1:       branch_target = $urandom;
        default: branch_target = $urandom & 32'h0000_FFFC;
      endcase
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        if ($urandom_range(0, 1) == 0) #2;
        rst = 1'b1;
      end
    end
    idle_inputs();
    rst = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_control.md
Name: pc_fetch_control

Overview:
- Program-counter and fetch-sequencing stage of the KGP miniRISC core.
- Sits directly upstream of the instruction-memory address port and the pipeline flip-flops that capture the fetched instruction.
- Owns the PC register and produces the fetch-valid qualifier consumed by those flops.
- Applies branch redirects, stalls and halt, and maintains a fetch counter.

Parameters:
- PC_W, 32, PC and branch-target width in bits.
- PC_STEP, 4, byte increment per sequential fetch (word-aligned instructions).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold the current PC this cycle (downstream not ready).
- branch_taken  input  1  redirect request from execute.
- branch_target  input  PC_W  redirect address; sampled when branch_taken=1.
- halt  input  1  halt request (HALT instruction decoded).
- pc  output  PC_W  current fetch address.
- fetch_valid  output  1  pc is a valid fetch this cycle.
- halted  output  1  core halted.
- misalign  output  1  sticky flag: a misaligned branch target was seen.
- fetch_count  output  32  number of accepted fetches.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- While rst=1, independent of clk:
  - state=BOOT, pc=RESET_PC, fetch_valid=0, halted=0, misalign=0, fetch_count=0.
- States: BOOT, RUN, FLUSH, HALT. Outputs are registered or decoded from state only, never combinationally from inputs.
- fetch_valid=1 only in RUN. halted=1 only in HALT.
- BOOT:
  - Next edge -> RUN; pc unchanged.
  - halt during BOOT -> HALT.
- RUN, per-edge priority:
  - halt=1 -> HALT; pc holds.
  - else branch_taken=1 with branch_target[1:0]!=0 (only when PC_STEP=4) -> HALT, misalign<=1, pc holds.
  - else branch_taken=1 -> pc<=branch_target, state->FLUSH. Branch overrides stall.
  - else stall=1 -> pc holds, stay RUN (fetch_valid stays 1).
  - else pc<=pc+PC_STEP, stay RUN.
- FLUSH:
  - One bubble cycle; pc holds the target.
  - branch_taken and stall are ignored.
  - Next edge -> RUN, so the target is fetched with fetch_valid=1 one cycle after redirect.
  - halt=1 in FLUSH -> HALT.
- HALT:
  - Terminal; all inputs ignored; pc frozen. Exit only via rst.
- fetch_count:
  - Increments on every edge where state=RUN and stall=0 and halt=0. A branching cycle counts; the misaligned-branch cycle does not.
  - Wraps 0xFFFFFFFF -> 0.
- Arithmetic:
  - pc+PC_STEP is modulo 2^PC_W. 0xFFFFFFFC + 4 -> 0x00000000 with no flag.
- Reset mid-operation: asynchronous return to BOOT values regardless of state or pending branch.

Test Plan:
- Reset release, no stimulus -> pc=0 with fetch_valid=0 for 1 cycle, then pc=0,4,8,12 on successive cycles with fetch_valid=1; fetch_count=3 after the 4th RUN edge.
- At pc=0x10, stall for 3 cycles -> pc stays 0x10, fetch_valid=1, fetch_count frozen; next free cycle pc=0x14.
- At pc=0x20, branch_taken=1, target=0x100, stall=1 simultaneously -> next cycle pc=0x100 with fetch_valid=0 (FLUSH); following cycle fetch_valid=1; then pc=0x104.
- branch_taken=1 with target=0x102 -> halted=1, misalign=1, pc frozen at the branching pc; further branches and stalls have no effect until rst.
- halt=1 and branch_taken=1 in the same RUN cycle -> HALT with pc unchanged; halt asserted during FLUSH -> HALT with pc=target.
- Force pc near 0xFFFFFFF8 via branch, then run -> 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; assert rst mid-sequence (between edges) -> outputs return to reset values immediately.
